mul_sequencer: RTL and testbench
================================

Name: mul_sequencer

Overview:
- Iterative shift-add multiply sequencer for the multicycle core's MUL/UMULL/SMULL support.
- Accepts two operands on a start strobe and runs a radix-2 multiply over several cycles.
- Holds Busy high while running, which the main FSM uses to stall the Execute state. Pulses Done with a valid 2*WIDTH product.
- Sits beside the ALU in the datapath. It is controlled by the decode logic: Start comes from the Execute state of multiply instructions.

Parameters:
- WIDTH, 32: operand width in bits; the product is 2*WIDTH bits.
- EARLY_EXIT, 1: when 1, RUN ends once the remaining multiplier bits are all zero; when 0, RUN always lasts WIDTH cycles.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- Start  input  1  request strobe; sampled only in IDLE.
- Signed  input  1  1 = two's-complement operands (SMULL); 0 = unsigned (MUL/UMULL); sampled with Start.
- SrcA  input  WIDTH  multiplicand; sampled with Start.
- SrcB  input  WIDTH  multiplier; sampled with Start.
- Busy  output  1  high in RUN and DONE.
- Done  output  1  high for exactly one cycle, in DONE.
- Product  output  2*WIDTH  result register. Valid from Done until the next accepted Start.

Behaviour:
- Reset (asynchronous):
  - state=IDLE, Busy=0, Done=0, Product=0, step counter=0, internal operand registers=0.
  - Reset mid-RUN or mid-DONE aborts the operation immediately; no Done is issued.
- States:
  - IDLE: if Start=1, go to RUN.
  - RUN: go to DONE when the counter reaches WIDTH-1, or (EARLY_EXIT=1) when the shifted multiplier is zero after the current step.
  - DONE: go to IDLE unconditionally after one cycle.
- Accept (IDLE && Start):
  - Latch sign = Signed & (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]).
  - Latch the operand magnitudes. For Signed=1, negate negative operands; the magnitude is interpreted unsigned, so -2^(WIDTH-1) maps to 2^(WIDTH-1).
  - Clear the accumulator and set the counter to 0.
- RUN step, one per cycle:
  - If the multiplier LSB is 1, accumulator += multiplicand (2*WIDTH-bit add, no overflow possible).
  - Shift the multiplicand left by 1 and the multiplier right by 1; counter += 1.
  - There is at least one RUN cycle even when SrcB=0.
- On the transition into DONE, Product = sign ? -(accumulator) mod 2^(2*WIDTH) : accumulator. Product then holds until the next accepted Start.
- Timing, with Start accepted at edge 0:
  - Busy=1 from cycle 1.
  - EARLY_EXIT=0: RUN occupies cycles 1..WIDTH; Done=1 in cycle WIDTH+1; IDLE in cycle WIDTH+2.
  - EARLY_EXIT=1: the RUN length equals the index of the highest set bit of |SrcB| plus 1, minimum 1.
- Start while Busy=1 (RUN or DONE) is ignored and not queued. Start in the cycle after DONE (IDLE) is accepted, so the back-to-back spacing is RUN length + 2 cycles.
- Signed, SrcA and SrcB are don't-care except at accept. Changes during RUN have no effect.
- Product changes on exactly two events: reset, and the transition into DONE. Accept does not clear Product.

Decomposition:
- Shared package (mul_pkg): state encoding constants IDLE=2'b00, RUN=2'b01, DONE=2'b10.
- Natural sub-module: mul_datapath, holding the operand, accumulator and shift registers plus the final conditional negate. mul_sequencer keeps the FSM, counter and handshake outputs.
- Encoding 2'b11 is unreachable and decodes to IDLE.

Test Plan:
- Unsigned, EARLY_EXIT=0: Start with SrcA=3, SrcB=5, Signed=0 at edge 0 -> Busy=1 in cycles 1..33; Done=1 only in cycle 33; Product=64'h0000000000000000F.
- Early exit: the same operands with EARLY_EXIT=1 -> Done in cycle 4, Product=15. Also SrcB=0 -> Done in cycle 2, Product=0.
- Signed: SrcA=32'hFFFFFFFD (-3), SrcB=5, Signed=1 -> Product=64'hFFFFFFFFFFFFFFF1.
- Signed extremes: SrcA=SrcB=32'h80000000, Signed=1 -> Product=64'h4000000000000000.
- Unsigned extremes: SrcA=SrcB=32'hFFFFFFFF, Signed=0 -> Product=64'hFFFFFFFE00000001.
- Ignored Start and reset abort:
  - Pulse Start again during RUN -> no restart, one Done only.
  - Assert reset during RUN -> Busy=0 and Product=0 immediately (asynchronous); no Done follows.

Source files
------------

// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_pkg
// Description : Shared definitions for the iterative multiply sequencer.
//               Holds the FSM state encoding used by mul_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package mul_pkg;

    // 2'b11 is never entered; the sequencer treats it as IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } mul_state_t;

endpackage : mul_pkg
`default_nettype wire

// File: rtl/mul_datapath.sv
`default_nettype none
// ============================================================================
// Module      : mul_datapath
// Description : Operand, accumulator and shift registers of the radix-2
//               shift-add multiplier, plus the final conditional negate.
//               Operands are reduced to unsigned magnitudes at accept; the
//               latched sign is applied once when the result is written.
// Ports       : clk, reset   - clock, asynchronous active-high reset
//               accept       - load operands, clear accumulator
//               step         - perform one shift-add iteration
//               finish       - write (possibly negated) result to product
//               signed_op    - operands are two's complement
//               src_a, src_b - multiplicand / multiplier
//               drained      - multiplier is zero after the current step
//               product      - 2*WIDTH-bit result register
// Revision    : 1.0 - initial release
// ============================================================================
module mul_datapath #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               accept,
    input  logic               step,
    input  logic               finish,
    input  logic               signed_op,
    input  logic [WIDTH-1:0]   src_a,
    input  logic [WIDTH-1:0]   src_b,
    output logic               drained,
    output logic [2*WIDTH-1:0] product
);

    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic               r_sign;

    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0]   w_mplier_next;

    // Magnitudes are read as unsigned, so the most negative value negates
    // to itself and still means 2^(WIDTH-1).
    assign w_mag_a = (signed_op && src_a[WIDTH-1]) ? -src_a : src_a;
    assign w_mag_b = (signed_op && src_b[WIDTH-1]) ? -src_b : src_b;

    // Accumulator value including the current step; the result must be
    // taken from this, not from r_acc, on the cycle the FSM leaves RUN.
    assign w_acc_next    = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_mplier_next = r_mplier >> 1;
    assign drained       = (w_mplier_next == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_sign   <= 1'b0;
            product  <= '0;
        end else begin
            if (accept) begin
                r_sign   <= signed_op & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
                r_mplier <= w_mag_b;
                r_acc    <= '0;
            end else if (step) begin
                r_acc    <= w_acc_next;
                r_mcand  <= r_mcand << 1;
                r_mplier <= w_mplier_next;
            end
            // Product is only ever written here; accept leaves it alone.
            if (finish) begin
                product <= r_sign ? -w_acc_next : w_acc_next;
            end
        end
    end

endmodule : mul_datapath
`default_nettype wire

// File: rtl/mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mul_sequencer
// Description : Iterative shift-add multiply sequencer (MUL/UMULL/SMULL).
//               Accepts operands on Start in IDLE, runs one radix-2 step per
//               cycle in RUN, pulses Done for one cycle with the product.
// Ports       : clk     - system clock
//               reset   - asynchronous active-high reset
//               Start   - request strobe, sampled only in IDLE
//               Signed  - 1 = two's complement operands
//               SrcA    - multiplicand, SrcB - multiplier
//               Busy    - high in RUN and DONE (stalls Execute)
//               Done    - one-cycle completion pulse
//               Product - 2*WIDTH-bit result, held until the next result
// Revision    : 1.0 - initial release
// ============================================================================
module mul_sequencer
    import mul_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               Start,
    input  logic               Signed,
    input  logic [WIDTH-1:0]   SrcA,
    input  logic [WIDTH-1:0]   SrcB,
    output logic               Busy,
    output logic               Done,
    output logic [2*WIDTH-1:0] Product
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    mul_state_t        r_state;
    logic [CNT_W-1:0]  r_count;

    logic w_idle;
    logic w_run;
    logic w_accept;
    logic w_last;
    logic w_finish;
    logic w_drained;

    // Anything other than RUN or DONE (including the unused 2'b11) is IDLE.
    assign w_run    = (r_state == RUN);
    assign w_idle   = !(w_run || (r_state == DONE));
    assign w_accept = w_idle && Start;

    // Last RUN step: counter exhausted, or nothing left in the multiplier.
    assign w_last   = (r_count == CNT_W'(WIDTH - 1)) ||
                      ((EARLY_EXIT != 1'b0) && w_drained);
    assign w_finish = w_run && w_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_count <= '0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    r_count <= r_count + CNT_W'(1);
                    if (w_last) begin
                        r_state <= DONE;
                        Done    <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    Busy    <= 1'b0;
                    Done    <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    if (Start) begin
                        r_state <= RUN;
                        r_count <= '0;
                        Busy    <= 1'b1;
                    end
                end
            endcase
        end
    end

    mul_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk       (clk),
        .reset     (reset),
        .accept    (w_accept),
        .step      (w_run),
        .finish    (w_finish),
        .signed_op (Signed),
        .src_a     (SrcA),
        .src_b     (SrcB),
        .drained   (w_drained),
        .product   (Product)
    );

endmodule : mul_sequencer
`default_nettype wire

// File: tb/tb_mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_sequencer
// Description : Self-checking bench for mul_sequencer. Two instances share
//               the stimulus: one with EARLY_EXIT=0, one with EARLY_EXIT=1.
//               Expected products come from plain 64-bit arithmetic and the
//               expected run length from the magnitude's highest set bit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_sequencer;

    localparam int W = 32;

    logic          clk;
    logic          reset;
    logic          Start;
    logic          Signed;
    logic [W-1:0]  SrcA;
    logic [W-1:0]  SrcB;
    logic          busy0, done0, busy1, done1;
    logic [2*W-1:0] prod0, prod1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [2*W-1:0] prev0, prev1;

    mul_sequencer #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut0 (
        .clk(clk), .reset(reset), .Start(Start), .Signed(Signed),
        .SrcA(SrcA), .SrcB(SrcB), .Busy(busy0), .Done(done0), .Product(prod0)
    );

    mul_sequencer #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut1 (
        .clk(clk), .reset(reset), .Start(Start), .Signed(Signed),
        .SrcA(SrcA), .SrcB(SrcB), .Busy(busy1), .Done(done1), .Product(prod1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference product from plain arithmetic on sign-/zero-extended operands.
    function automatic logic [63:0] model_prod(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [63:0] sa, sb;
        if (s) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            return sa * sb;
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    // Early-exit run length: index of highest set bit of |b| plus one, min 1.
    function automatic int model_len(input logic [31:0] b, input logic s);
        logic [31:0] mag;
        int len;
        mag = (s && b[31]) ? -b : b;
        len = 1;
        for (int i = 0; i < 32; i++) if (mag[i]) len = i + 1;
        return len;
    endfunction

    // One complete operation observed on both instances. Cycle numbering:
    // Start accepted at edge 0, cycle k sampled at the negedge after edge k.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [63:0] exp, input bit poke);
        int d0c, d1c, n0, n1, b0, b1, len;
        d0c = 0; d1c = 0; n0 = 0; n1 = 0; b0 = 0; b1 = 0;
        len = model_len(b, s);
        @(negedge clk);
        Start = 1'b1; SrcA = a; SrcB = b; Signed = s;
        @(posedge clk);
        @(negedge clk);
        Start = 1'b0;
        for (int cyc = 1; cyc <= W + 3; cyc++) begin
            if (cyc == 1) begin
                check("hold_before_done0", prod0, prev0);
                check("hold_before_done1", prod1, prev1);
            end
            if (busy0) b0++;
            if (busy1) b1++;
            if (done0) begin n0++; d0c = cyc; end
            if (done1) begin n1++; d1c = cyc; end
            // Inputs are don't-care outside accept.
            SrcA   = $urandom;
            SrcB   = $urandom;
            Signed = 1'($urandom_range(0, 1));
            Start  = poke && (cyc == 2);
            @(negedge clk);
        end
        Start = 1'b0;
        check("done_count0", 64'(n0), 64'd1);
        check("done_cycle0", 64'(d0c), 64'(W + 1));
        check("busy_cycles0", 64'(b0), 64'(W + 1));
        check("product0", prod0, exp);
        check("done_count1", 64'(n1), 64'd1);
        check("done_cycle1", 64'(d1c), 64'(len + 1));
        check("busy_cycles1", 64'(b1), 64'(len + 1));
        check("product1", prod1, exp);
        prev0 = exp;
        prev1 = exp;
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [63:0] exp;
    } vec_t;

    vec_t tbl[6];

    initial begin
        tbl[0] = '{32'd3,          32'd5,          1'b0, 64'h000000000000000F};
        tbl[1] = '{32'd3,          32'd0,          1'b0, 64'h0000000000000000};
        tbl[2] = '{32'hFFFFFFFD,   32'd5,          1'b1, 64'hFFFFFFFFFFFFFFF1};
        tbl[3] = '{32'h80000000,   32'h80000000,   1'b1, 64'h4000000000000000};
        tbl[4] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, 64'hFFFFFFFE00000001};
        tbl[5] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   1'b1, 64'h0000000000000001};

        reset = 1'b1; Start = 1'b0; Signed = 1'b0; SrcA = '0; SrcB = '0;
        prev0 = '0; prev1 = '0;
        #12;
        check("reset_busy0", 64'(busy0), 64'd0);
        check("reset_done0", 64'(done0), 64'd0);
        check("reset_product0", prod0, 64'd0);
        check("reset_busy1", 64'(busy1), 64'd0);
        check("reset_product1", prod1, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed vectors.
        for (int i = 0; i < 6; i++)
            run_op(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].exp, 1'b0);

        // Start during RUN must be ignored; multiplier with bit 31 set keeps
        // the early-exit instance running past the poke too.
        run_op(32'd1234567, 32'h80000011, 1'b0,
               model_prod(32'd1234567, 32'h80000011, 1'b0), 1'b1);

        // Randomized operands, with varied multiplier magnitudes so the
        // early-exit length spreads across the whole range.
        for (int i = 0; i < 24; i++) begin
            logic [31:0] ra, rb;
            logic        rs;
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 3) == 0) rb = -rb;
            rs = 1'($urandom_range(0, 1));
            run_op(ra, rb, rs, model_prod(ra, rb, rs), 1'b0);
        end

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        Start = 1'b1; SrcA = 32'd7; SrcB = 32'hF0000000; Signed = 1'b0;
        @(posedge clk);
        @(negedge clk);
        Start = 1'b0;
        repeat (5) @(negedge clk);
        check("busy_mid_run0", 64'(busy0), 64'd1);
        check("busy_mid_run1", 64'(busy1), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("abort_busy0", 64'(busy0), 64'd0);
        check("abort_busy1", 64'(busy1), 64'd0);
        check("abort_product0", prod0, 64'd0);
        check("abort_product1", prod1, 64'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        begin
            int nd;
            nd = 0;
            for (int cyc = 0; cyc < W + 8; cyc++) begin
                if (done0 || done1 || busy0 || busy1) nd++;
                @(negedge clk);
            end
            check("no_activity_after_abort", 64'(nd), 64'd0);
        end
        prev0 = '0;
        prev1 = '0;

        // Normal operation resumes after the abort.
        run_op(32'd3, 32'd5, 1'b0, 64'd15, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_mul_sequencer
`default_nettype wire
